// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the mult_sched multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_D_IN      = 8;
  localparam int unsigned DEF_TO_CYCLES = 64;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Requester and multiplier-side signal bundle for mult_sched.
interface mult_sched_if
  import mult_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned D_IN  = DEF_D_IN
) ();

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*D_IN-1:0] req_a;
  logic [N_REQ*D_IN-1:0] req_b;
  logic [N_REQ-1:0]      rsp_valid;
  logic [N_REQ-1:0]      rsp_ready;
  logic [2*D_IN-1:0]     rsp_p;
  logic                  rsp_err;
  logic                  mul_start;
  logic [D_IN-1:0]       mul_a;
  logic [D_IN-1:0]       mul_b;
  logic                  mul_done;
  logic [2*D_IN-1:0]     mul_p;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_p,
    output req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_p,
    input  req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b, busy
  );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, searching circularly.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_pos = ((32'(ptr) + k) >= N_REQ) ? IDX_W'(32'(ptr) + k - N_REQ)
                                        : IDX_W'(32'(ptr) + k);
      if (!w_found && req[w_pos]) begin
        w_found      = 1'b1;
        gnt[w_pos]   = 1'b1;
        gnt_idx      = w_pos;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential Booth multiplier among N_REQ requesters.
// Optional WAIT watchdog is enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned D_IN      = DEF_D_IN,
  parameter int unsigned TO_CYCLES = DEF_TO_CYCLES
) (
  input logic         clk,
  input logic         rst,
  mult_sched_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(N_REQ);
  localparam int unsigned P_W   = 2 * D_IN;

  state_e           r_state;
  state_e           w_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gidx;
  logic [IDX_W-1:0] w_gidx;
  logic [N_REQ-1:0] w_gnt;
  logic [D_IN-1:0]  r_mul_a;
  logic [D_IN-1:0]  r_mul_b;
  logic [P_W-1:0]   r_rsp_p;
  logic             r_rsp_err;
  logic             w_accept;
  logic             w_rsp_hs;
  logic             w_done;
  logic             w_to_hit;
  logic [D_IN-1:0]  w_a_arr [N_REQ];
  logic [D_IN-1:0]  w_b_arr [N_REQ];

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gidx)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_a_arr[i] = bus.req_a[i*D_IN +: D_IN];
    assign w_b_arr[i] = bus.req_b[i*D_IN +: D_IN];
  end

  assign w_accept = (r_state == S_IDLE) && !rst && (|bus.req_valid);
  assign w_rsp_hs = (r_state == S_RESP) && bus.rsp_ready[r_gidx];
  assign w_done   = (r_state == S_WAIT) && bus.mul_done;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = idx_w(TO_CYCLES);
  logic [CNT_W-1:0] r_to_cnt;

  // Watchdog: cleared while launching, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + CNT_W'(1);
    end
  end

  assign w_to_hit = (r_state == S_WAIT) && !bus.mul_done
                    && (r_to_cnt == CNT_W'(TO_CYCLES - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done || w_to_hit) w_next = S_RESP;
      S_RESP:  if (w_rsp_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, result capture and pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_rsp_p   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gidx  <= w_gidx;
        r_mul_a <= w_a_arr[w_gidx];
        r_mul_b <= w_b_arr[w_gidx];
      end
      if (w_done) begin
        r_rsp_p   <= bus.mul_p;
        r_rsp_err <= 1'b0;
      end else if (w_to_hit) begin
        r_rsp_p   <= '0;
        r_rsp_err <= 1'b1;
      end
      if (w_rsp_hs) begin
        r_ptr <= (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);
      end
    end
  end

  assign bus.req_ready = w_accept ? w_gnt : '0;
  assign bus.rsp_valid = (r_state == S_RESP) ? (N_REQ'(1) << r_gidx) : '0;
  assign bus.rsp_p     = r_rsp_p;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mul_start = (r_state == S_ISSUE);
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
